// File: rtl/bcd_scan_display.sv
//==============================================================================
// Module   : bcd_scan_display
// Brief    : Time-multiplexed seven-segment scanner for a chain of BCD digits,
//            with per-frame shadow capture and a one-cycle ghost-blanking gap.
//            Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_scan_display #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int IDXW = $clog2(DIGITS);
    localparam int CNTW = $clog2(DIV);

    localparam logic              c_inv      = (ACTIVE_LOW != 0);
    localparam logic [IDXW-1:0]   c_last_idx = IDXW'(DIGITS - 1);
    localparam logic [CNTW-1:0]   c_last_cnt = CNTW'(DIV - 1);
    localparam logic [DIGITS-1:0] c_one      = DIGITS'(1);
    localparam logic [6:0]        c_seg_off  = {7{c_inv}};
    localparam logic [DIGITS-1:0] c_an_off   = {DIGITS{c_inv}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDXW-1:0]       r_idx;
    logic [CNTW-1:0]       r_cnt;
    logic [4*DIGITS-1:0]   r_shadow_bcd;
    logic [DIGITS-1:0]     r_shadow_dp;

    logic                  w_capture;
    logic [4*DIGITS-1:0]   w_src_bcd;
    logic [DIGITS-1:0]     w_src_dp;
    logic [3:0]            w_digit;
    logic                  w_dp_sel;
    logic [6:0]            w_seg_dec;
    logic                  w_blank;
    logic [6:0]            w_seg_ah;

    // The slot lit on a capture edge must show the value being captured,
    // so the display path reads straight from the inputs on that edge.
    assign w_capture = (r_state == ST_BLANK) && (r_idx == '0);
    assign w_src_bcd = w_capture ? bcd : r_shadow_bcd;
    assign w_src_dp  = w_capture ? dp  : r_shadow_dp;
    assign w_digit   = w_src_bcd[{r_idx, 2'b00} +: 4];
    assign w_dp_sel  = w_src_dp[r_idx];

    always_comb begin
        w_seg_dec = 7'h40;
        case (w_digit)
            4'd0:    w_seg_dec = 7'h3F;
            4'd1:    w_seg_dec = 7'h06;
            4'd2:    w_seg_dec = 7'h5B;
            4'd3:    w_seg_dec = 7'h4F;
            4'd4:    w_seg_dec = 7'h66;
            4'd5:    w_seg_dec = 7'h6D;
            4'd6:    w_seg_dec = 7'h7D;
            4'd7:    w_seg_dec = 7'h07;
            4'd8:    w_seg_dec = 7'h7F;
            4'd9:    w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h40;
        endcase
    end

`ifdef BCD_SCAN_LZB_EN
    // w_zero_above[i] is set when digits i..DIGITS-1 are all zero.
    logic [DIGITS:0] w_zero_above;

    assign w_zero_above[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
            assign w_zero_above[gi] = (w_src_bcd[4*gi +: 4] == 4'd0) && w_zero_above[gi+1];
        end
    endgenerate

    assign w_blank = (r_idx != '0) && w_zero_above[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_ah = w_blank ? 7'h00 : w_seg_dec;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= ST_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            seg          <= c_seg_off;
            dp_o         <= c_inv;
            an           <= c_an_off;
            frame        <= 1'b0;
        end else begin
            frame <= 1'b0;
            case (r_state)
                ST_BLANK: begin
                    r_state <= ST_SHOW;
                    if (w_capture) begin
                        r_shadow_bcd <= bcd;
                        r_shadow_dp  <= dp;
                        frame        <= 1'b1;
                    end
                    seg  <= w_seg_ah ^ c_seg_off;
                    dp_o <= w_dp_sel ^ c_inv;
                    an   <= (c_one << r_idx) ^ c_an_off;
                end
                ST_SHOW: begin
                    // With en low everything simply holds.
                    if (en) begin
                        if (r_cnt == c_last_cnt) begin
                            r_cnt   <= '0;
                            r_idx   <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                            r_state <= ST_BLANK;
                            seg     <= c_seg_off;
                            dp_o    <= c_inv;
                            an      <= c_an_off;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with DIGITS=4, DIV=4, active-low outputs.
`default_nettype none

module tb_bcd_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dp;
        logic [3:0][6:0]  seg;   // expected seg per digit, [0] = digit 0
        logic [3:0]       dpo;   // expected dp_o per digit
    } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dp  = '0;
    logic [6:0]  seg;
    logic        dp_o;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    bcd_scan_display #(
        .DIGITS    (DIGITS),
        .DIV       (DIV),
        .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .bcd  (bcd),
        .dp   (dp),
        .seg  (seg),
        .dp_o (dp_o),
        .an   (an),
        .frame(frame)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] an_lit(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    // Pulse reset between edges and start a fresh frame with new inputs.
    task automatic restart(input logic [15:0] b, input logic [3:0] d);
        clr = 1'b0;
        bcd = b;
        dp  = d;
        en  = 1'b1;
        #1;
        clr = 1'b1;
    endtask

    // One full digit slot: DIV lit cycles then one blank cycle.
    task automatic check_slot(input int k, input logic [6:0] es, input logic edp, input logic efr);
        tick();
        check($sformatf("slot%0d_an", k), an, an_lit(k));
        check($sformatf("slot%0d_seg", k), seg, es);
        check($sformatf("slot%0d_dpo", k), dp_o, edp);
        check($sformatf("slot%0d_frame", k), frame, efr);
        for (int c = 1; c < DIV; c++) begin
            tick();
            check($sformatf("slot%0d_hold_an", k), an, an_lit(k));
            check($sformatf("slot%0d_hold_seg", k), seg, es);
            check($sformatf("slot%0d_hold_frame", k), frame, 1'b0);
        end
        tick();
        check($sformatf("slot%0d_blank_an", k), an, 4'hF);
        check($sformatf("slot%0d_blank_seg", k), seg, 7'h7F);
        check($sformatf("slot%0d_blank_dpo", k), dp_o, 1'b1);
    endtask

    initial begin
        vecs[0] = '{bcd: 16'h1234, dp: 4'b0000, seg: {7'h79, 7'h24, 7'h30, 7'h19}, dpo: 4'b1111};
        vecs[1] = '{bcd: 16'h567C, dp: 4'b0001, seg: {7'h12, 7'h02, 7'h78, 7'h3F}, dpo: 4'b1110};
`ifdef BCD_SCAN_LZB_EN
        vecs[2] = '{bcd: 16'h0005, dp: 4'b0000, seg: {7'h7F, 7'h7F, 7'h7F, 7'h12}, dpo: 4'b1111};
`else
        vecs[2] = '{bcd: 16'h0005, dp: 4'b0000, seg: {7'h40, 7'h40, 7'h40, 7'h12}, dpo: 4'b1111};
`endif
        vecs[3] = '{bcd: 16'h8060, dp: 4'b1010, seg: {7'h00, 7'h40, 7'h02, 7'h40}, dpo: 4'b0101};
        vecs[4] = '{bcd: 16'h9999, dp: 4'b1111, seg: {7'h10, 7'h10, 7'h10, 7'h10}, dpo: 4'b0000};

        // Reset held with the clock running.
        repeat (3) tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dpo", dp_o, 1'b1);
        check("rst_frame", frame, 1'b0);

        // Table-driven frames; the trailing digit-0 slot proves the 20-cycle period.
        for (int v = 0; v < 5; v++) begin
            restart(vecs[v].bcd, vecs[v].dp);
            for (int k = 0; k < DIGITS; k++)
                check_slot(k, vecs[v].seg[k], vecs[v].dpo[k], (k == 0));
            tick();
            check($sformatf("v%0d_relit_an", v), an, 4'b1110);
            check($sformatf("v%0d_relit_frame", v), frame, 1'b1);
        end

        // Asynchronous reset while digit 2 is lit.
        restart(16'h1234, 4'b0000);
        check_slot(0, 7'h19, 1'b1, 1'b1);
        check_slot(1, 7'h30, 1'b1, 1'b0);
        tick();
        check("midrst_pre_an", an, 4'b1011);
        #2;
        clr = 1'b0;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dpo", dp_o, 1'b1);
        check("midrst_frame", frame, 1'b0);

        // Snapshot: input change mid-frame must not tear the display.
        tick();
        restart(16'h1234, 4'b0000);
        check_slot(0, 7'h19, 1'b1, 1'b1);
        check_slot(1, 7'h30, 1'b1, 1'b0);
        tick();
        check("snap_d2_an", an, 4'b1011);
        bcd = 16'h9999;
        dp  = 4'b1111;
        for (int c = 1; c < DIV; c++) begin
            tick();
            check("snap_d2_seg", seg, 7'h24);
        end
        tick();
        check("snap_d2_blank", an, 4'hF);
        check_slot(3, 7'h79, 1'b1, 1'b0);
        check_slot(0, 7'h10, 1'b0, 1'b1);

        // Hold: en low freezes digit 1, then the remaining count completes.
        restart(16'h1234, 4'b0000);
        check_slot(0, 7'h19, 1'b1, 1'b1);
        tick();
        check("hold_enter_an", an, 4'b1101);
        tick();
        en = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("hold_an", an, 4'b1101);
            check("hold_seg", seg, 7'h30);
        end
        en = 1'b1;
        tick();
        check("hold_rem1_an", an, 4'b1101);
        tick();
        check("hold_rem2_an", an, 4'b1101);
        tick();
        check("hold_blank_an", an, 4'hF);
        check("hold_blank_seg", seg, 7'h7F);
        check_slot(2, 7'h24, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment driver that sits directly downstream of a chain of BCD counter digits. It consumes DIGITS packed 4-bit BCD values plus per-digit decimal points and scans them onto a common-anode/cathode display, one digit at a time. Each frame is latched into a shadow register so that counter updates cannot tear a displayed value. A one-cycle ghost-blanking gap separates consecutive digits.

## Interface
- DIGITS, 4, number of digits scanned; legal range 2..8.
- DIV, 1000, clk cycles (with en high) each digit stays lit; minimum 2.
- ACTIVE_LOW, 1, 1 means seg, dp_o and an are active-low; 0 means active-high.
- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous, active-low.
- en  in  1  prescaler advance enable.
- bcd  in  4*DIGITS  digit i is bcd[4i+3:4i]; digit 0 is least significant.
- dp  in  DIGITS  decimal point request, dp[i] belongs to digit i; active-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- dp_o  out  1  decimal point segment, registered.
- an  out  DIGITS  digit enables, one-hot when lit; an[i] drives digit i; registered.
- frame  out  1  one-cycle pulse at the start of each frame.

## Operation
- State: BLANK and SHOW. Registers: state, idx (clog2(DIGITS) bits), prescaler cnt (clog2(DIV) bits), shadow digits and dp.
- "Inactive" means logic 1 when ACTIVE_LOW=1 and logic 0 otherwise. All output polarity inversion is applied at the output registers.
- Reset state: BLANK, idx=0, cnt=0, shadow=0. While clr is low: an all inactive, seg all inactive, dp_o inactive, frame=0. Asserting clr mid-operation forces these values immediately, without waiting for clk.
- BLANK: lasts exactly one cycle, regardless of en. Outputs are inactive during BLANK. The next state is always SHOW.
- BLANK→SHOW with idx=0: shadow captures bcd and dp, and frame=1 for the first SHOW cycle. This also applies to the first frame after reset.
- SHOW: an[idx] is active and all other an bits are inactive. seg=decode(shadow[idx]). dp_o follows shadow dp[idx].
  - With en=1, cnt increments each cycle.
  - With en=0, cnt and all outputs hold.
- SHOW exit: when en=1 and cnt=DIV-1, cnt←0, idx←idx+1 (wrapping DIGITS-1→0), and state←BLANK.
- Decode, active-high {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Values 10..15 display a dash (40).
- The bcd and dp inputs are sampled only at the capture point. Changes at any other time are ignored until the next frame.

## Timing
- Each digit slot is DIV+1 cycles while en is held high: DIV cycles lit plus one BLANK cycle.
- A full frame is DIGITS*(DIV+1) cycles.
- Outputs are registered. Lit values appear on the clk edge that enters SHOW.
- Capture-to-display latency is 1 cycle for digit 0 and k*(DIV+1)+1 cycles for digit k.
- The first edge after clr is released moves BLANK→SHOW, lighting digit 0 with the freshly captured bcd.

## Configuration
- BCD_SCAN_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i>0 is blanked when shadow digits i..DIGITS-1 are all 0.
  - A blanked digit drives seg all inactive, but an[i] still scans and dp_o still follows dp[i].
  - Digit 0 is never blanked.
- BCD_SCAN_LZB_EN undefined: every digit is decoded normally, with zeros shown as 0.

## Test plan
All tests use DIGITS=4, DIV=4, ACTIVE_LOW=1.
- Reset: hold clr=0 and toggle clk → an=4'hF, seg=7'h7F, dp_o=1, frame=0. Pulse clr low mid-SHOW → the same values appear at once, asynchronously.
- Scan: bcd=16'h1234, dp=0, en=1, release clr.
  - First edge: an=4'b1110, seg=7'h19, frame=1.
  - Digit 0 stays lit for 4 cycles, then 1 cycle with an=4'hF.
  - Then an=4'b1101, seg=7'h30.
  - Digit 0 is relit after exactly 20 cycles.
- Snapshot: change bcd to 16'h9999 while digit 2 is lit → digits 2 and 3 still show 2 (7'h24) and 1 (7'h79). Digit 0 shows 9 (7'h10) only from the next frame.
- Invalid and dp: bcd[3:0]=4'hC, dp=4'b0001 → digit 0 shows seg=7'h3F, dp_o=0. Other digits show dp_o=1.
- Hold: drop en for 50 cycles while digit 1 is lit → an and seg are frozen. Raise en → the remaining count completes, followed by BLANK.
- LZB: bcd=16'h0005.
  - With BCD_SCAN_LZB_EN defined: digits 1..3 show seg=7'h7F with an still scanning.
  - Without it: digits 1..3 show seg=7'h40.
  - Digit 0 shows 7'h12 in both builds.
